// File: rtl/tq_pass_sched_if.sv
// tq_pass_sched handshake bundle: start/size/stall in, beat strobes out.
// slave = sequencer side, master = driver side.
interface tq_pass_sched_if;
  logic       i_start;
  logic [1:0] i_transize;
  logic       i_stall;
  logic       o_busy;
  logic       o_row_valid;
  logic [4:0] o_row_idx;
  logic       o_wen;
  logic       o_col_valid;
  logic [4:0] o_col_idx;
  logic       o_done;

  modport slave (
    input  i_start, i_transize, i_stall,
    output o_busy, o_row_valid, o_row_idx,
    output o_wen, o_col_valid, o_col_idx,
    output o_done
  );

  modport master (
    output i_start, i_transize, i_stall,
    input  o_busy, o_row_valid, o_row_idx,
    input  o_wen, o_col_valid, o_col_idx,
    input  o_done
  );
endinterface

// File: rtl/tq_pass_sched.sv
// Two-pass TU sequencer: row beats, transpose write delay line, col beats.
// Ports: clk, rst (sync, active-high), bus (tq_pass_sched_if.slave).
module tq_pass_sched #(
  parameter int ROW_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  tq_pass_sched_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, ROW, FLUSH, COL, DONE
  } state_e;

  // Delay-line taps whose beat would still reach o_wen after this cycle.
  localparam logic [ROW_LAT-1:0] PEND_MASK =
    ROW_LAT'((64'd1 << (ROW_LAT - 1)) - 64'd1);

  state_e             state_q, state_d;
  logic [1:0]         size_q, size_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [5:0]         n_beats;
  logic               rv_q, rv_d;
  logic               cv_q, cv_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic [4:0]         ridx_q, ridx_d;
  logic [4:0]         cidx_q, cidx_d;
  logic [ROW_LAT-1:0] sr_q, sr_d;
  logic               pending;

  always_comb begin
    unique case (size_q)
      2'b00: n_beats = 6'd1;
      2'b01: n_beats = 6'd2;
      2'b10: n_beats = 6'd8;
      2'b11: n_beats = 6'd32;
    endcase
  end

  // Shifts every cycle; o_wen is the oldest tap.
  assign sr_d    = (sr_q << 1) | ROW_LAT'(rv_q);
  assign pending = rv_q | (|(sr_q & PEND_MASK));

  // cnt_q counts beats already issued in the current pass.
  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    rv_d    = 1'b0;
    cv_d    = 1'b0;
    done_d  = 1'b0;
    ridx_d  = ridx_q;
    cidx_d  = cidx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          size_d  = bus.i_transize;
          state_d = ROW;
          rv_d    = 1'b1;
          ridx_d  = 5'd0;
          cnt_d   = 6'd1;
        end
      end
      ROW: begin
        if (cnt_q == n_beats) begin
          state_d = FLUSH;
          cnt_d   = 6'd0;
        end else if (!bus.i_stall) begin
          rv_d   = 1'b1;
          ridx_d = cnt_q[4:0];
          cnt_d  = cnt_q + 6'd1;
        end
      end
      FLUSH: begin
        if (!pending) begin
          state_d = COL;
          cv_d    = 1'b1;
          cidx_d  = 5'd0;
          cnt_d   = 6'd1;
        end
      end
      COL: begin
        if (cnt_q == n_beats) begin
          state_d = DONE;
          done_d  = 1'b1;
          cnt_d   = 6'd0;
        end else if (!bus.i_stall) begin
          cv_d   = 1'b1;
          cidx_d = cnt_q[4:0];
          cnt_d  = cnt_q + 6'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      size_q  <= 2'b00;
      cnt_q   <= 6'd0;
      rv_q    <= 1'b0;
      cv_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ridx_q  <= 5'd0;
      cidx_q  <= 5'd0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      cv_q    <= cv_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ridx_q  <= ridx_d;
      cidx_q  <= cidx_d;
      sr_q    <= sr_d;
    end
  end

  assign bus.o_busy      = busy_q;
  assign bus.o_row_valid = rv_q;
  assign bus.o_row_idx   = ridx_q;
  assign bus.o_wen       = sr_q[ROW_LAT-1];
  assign bus.o_col_valid = cv_q;
  assign bus.o_col_idx   = cidx_q;
  assign bus.o_done      = done_q;

endmodule

// File: tb/tb_tq_pass_sched.sv
// Bench for tq_pass_sched: table of TU runs plus reset and back-to-back.
// Expected beat timing is queued at start and popped as the DUT emits.
module tb_tq_pass_sched;

  localparam int L = 2;
  localparam int NOLIM = 32'h3fff_ffff;

  typedef struct {
    int cyc;
    int idx;
  } beat_t;

  typedef struct {
    logic [1:0] size;
    int         stall;
    int         done_rel;
  } vec_t;

  logic clk;
  logic rst;
  int   cyc;
  int   nchk;
  int   nerr;
  int   last_done;

  beat_t row_q[$];
  beat_t col_q[$];
  int    wen_q[$];
  int    done_q[$];
  vec_t  vecs[6];

  tq_pass_sched_if ifc ();

  tq_pass_sched #(.ROW_LAT(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL timeout: cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input bit ok,
                     input int act, input int exp);
    nchk++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic int nbeats(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 8;
      default: return 32;
    endcase
  endfunction

  // Reference timing: first row beat at t0+1, a stall sampled at
  // edge t0+st drops that cycle's beat, o_wen lags by L, columns
  // start right after the last o_wen, done follows the last column.
  task automatic push_tu(input int t0, input int n, input int st,
                         input int lim, output int dc);
    int c;
    int last;
    beat_t b;
    c = t0 + 1;
    last = c;
    for (int i = 0; i < n; i++) begin
      if (st > 0 && c == t0 + st) c++;
      b.cyc = c;
      b.idx = i;
      if (c <= lim) row_q.push_back(b);
      if (c + L <= lim) wen_q.push_back(c + L);
      last = c;
      c++;
    end
    c = last + L + 1;
    for (int i = 0; i < n; i++) begin
      b.cyc = c;
      b.idx = i;
      if (c <= lim) col_q.push_back(b);
      c++;
    end
    dc = c;
    if (c <= lim) done_q.push_back(c);
  endtask

  always @(negedge clk) begin
    beat_t b;
    int    w;
    if (ifc.o_row_valid === 1'b1) begin
      if (row_q.size() == 0) begin
        chk("row_extra", 1'b0, cyc, -1);
      end else begin
        b = row_q.pop_front();
        chk("row_cyc", cyc == b.cyc, cyc, b.cyc);
        chk("row_idx", ifc.o_row_idx == 5'(b.idx),
            int'(ifc.o_row_idx), b.idx);
      end
    end
    if (ifc.o_wen === 1'b1) begin
      if (wen_q.size() == 0) begin
        chk("wen_extra", 1'b0, cyc, -1);
      end else begin
        w = wen_q.pop_front();
        chk("wen_cyc", cyc == w, cyc, w);
      end
    end
    if (ifc.o_col_valid === 1'b1) begin
      if (col_q.size() == 0) begin
        chk("col_extra", 1'b0, cyc, -1);
      end else begin
        b = col_q.pop_front();
        chk("col_cyc", cyc == b.cyc, cyc, b.cyc);
        chk("col_idx", ifc.o_col_idx == 5'(b.idx),
            int'(ifc.o_col_idx), b.idx);
      end
    end
    if (ifc.o_done === 1'b1) begin
      last_done = cyc;
      chk("done_busy", ifc.o_busy === 1'b1, int'(ifc.o_busy), 1);
      if (done_q.size() == 0) begin
        chk("done_extra", 1'b0, cyc, -1);
      end else begin
        w = done_q.pop_front();
        chk("done_cyc", cyc == w, cyc, w);
      end
    end
    if (ifc.o_col_valid === 1'b1)
      chk("excl", !ifc.o_row_valid && !ifc.o_wen,
          int'({ifc.o_row_valid, ifc.o_wen}), 0);
  end

  task automatic chk_drained(input string nm);
    int n;
    n = row_q.size() + wen_q.size() + col_q.size() + done_q.size();
    chk(nm, n == 0, n, 0);
    row_q.delete();
    wen_q.delete();
    col_q.delete();
    done_q.delete();
  endtask

  task automatic chk_idle(input string nm);
    logic [14:0] v;
    v = {ifc.o_busy, ifc.o_row_valid, ifc.o_row_idx, ifc.o_wen,
         ifc.o_col_valid, ifc.o_col_idx, ifc.o_done};
    chk(nm, v === 15'd0, int'(v), 0);
  endtask

  task automatic run_vec(input vec_t v);
    int t0;
    int dc;
    @(negedge clk);
    t0 = cyc;
    last_done = -1;
    push_tu(t0, nbeats(v.size), v.stall, NOLIM, dc);
    ifc.i_start = 1'b1;
    ifc.i_transize = v.size;
    for (int k = 1; k <= v.done_rel + 1; k++) begin
      @(negedge clk);
      ifc.i_start = 1'b0;
      ifc.i_transize = ~v.size;
      ifc.i_stall = (v.stall > 0 && k == v.stall - 1);
    end
    chk("busy_end", ifc.o_busy === 1'b0, int'(ifc.o_busy), 0);
    chk("done_lat", last_done - t0 == v.done_rel,
        last_done - t0, v.done_rel);
    chk_drained("drain");
  endtask

  initial begin
    int t0;
    int dc;
    nchk = 0;
    nerr = 0;
    cyc = 0;
    last_done = -1;
    rst = 1'b1;
    ifc.i_start = 1'b0;
    ifc.i_transize = 2'b00;
    ifc.i_stall = 1'b0;

    vecs[0] = '{2'b00, 0, 5};
    vecs[1] = '{2'b01, 0, 7};
    vecs[2] = '{2'b01, 2, 8};
    vecs[3] = '{2'b10, 0, 19};
    vecs[4] = '{2'b11, 0, 67};
    vecs[5] = '{2'b10, 5, 20};

    repeat (2) @(negedge clk);
    chk_idle("reset_state");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("idle_state");

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset mid-COL of a 32x32 TU: nothing after cycle 40 may appear.
    @(negedge clk);
    t0 = cyc;
    push_tu(t0, 32, 0, t0 + 40, dc);
    ifc.i_start = 1'b1;
    ifc.i_transize = 2'b11;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      ifc.i_start = 1'b0;
      if (k == 40) rst = 1'b1;
      if (k == 41) begin
        chk_idle("rst_mid_col");
        rst = 1'b0;
      end
    end
    chk_drained("rst_drain");
    run_vec('{2'b00, 0, 5});

    // Two 16x16 TUs with start held; size toggles must not matter.
    @(negedge clk);
    t0 = cyc;
    push_tu(t0, 8, 0, NOLIM, dc);
    push_tu(t0 + 20, 8, 0, NOLIM, dc);
    ifc.i_start = 1'b1;
    ifc.i_transize = 2'b10;
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      ifc.i_start = (k <= 30);
      if (k >= 5 && k <= 15) ifc.i_transize = 2'b00;
      else if (k >= 25 && k <= 30) ifc.i_transize = 2'b11;
      else ifc.i_transize = 2'b10;
      if (k == 20)
        chk("b2b_idle", ifc.o_busy === 1'b0, int'(ifc.o_busy), 0);
    end
    chk("b2b_end", ifc.o_busy === 1'b0, int'(ifc.o_busy), 0);
    chk("b2b_done", last_done - t0 == 39, last_done - t0, 39);
    chk_drained("b2b_drain");

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/tq_pass_sched.md
# tq_pass_sched

Two-pass sequencer for the transform/quantization stage. It runs one transform unit (TU) through the row transform. It then writes the row results into the transpose memory. Finally it reads them back out for the column transform. It issues per-beat valids and indices for both passes, the transpose-memory write enable, and a completion pulse, so the transpose memory no longer derives its own write timing from the input stream.

## Interface

Parameters:
- ROW_LAT, default 2: cycles from a row-pass beat to its transpose-memory write; legal range 1..4.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high. One clock, synchronous active-high reset.
- i_start  in  1  TU start request; sampled only in IDLE.
- i_transize  in  2  TU size: 00=4x4, 01=8x8, 10=16x16, 11=32x32; latched on accepted start.
- i_stall  in  1  freezes beat issue in ROW and COL.
- o_busy  out  1  high whenever state is not IDLE.
- o_row_valid  out  1  row-transform beat valid.
- o_row_idx  out  5  row beat index.
- o_wen  out  1  transpose-memory write enable.
- o_col_valid  out  1  column-transform beat valid (transpose-memory read).
- o_col_idx  out  5  column beat index.
- o_done  out  1  one-cycle TU completion pulse.

## Operation

- Beats per pass, N, depends on the latched size:
  - 00 gives N=1.
  - 01 gives N=2.
  - 10 gives N=8.
  - 11 gives N=32.
- Indices run from 0 to N-1, use 5-bit unsigned arithmetic, and never exceed N-1.
- FSM states and transitions:
  - IDLE: go to ROW on i_start; latch size.
  - ROW: issue beats. Go to FLUSH after beat N-1 is issued.
  - FLUSH: go to COL when no row beat remains in flight.
  - COL: issue beats. Go to DONE after beat N-1 is issued.
  - DONE: go to IDLE after one cycle.
- ROW, per cycle with i_stall=0:
  - o_row_valid=1 and o_row_idx equals the beat counter.
  - The counter then increments.
- ROW with i_stall=1: o_row_valid=0 and the counter holds.
- o_wen is o_row_valid delayed by exactly ROW_LAT cycles through a delay line.
  - The delay line shifts every cycle regardless of i_stall or state.
  - Gaps caused by stalls reappear as gaps on o_wen.
- FLUSH: leave when the delay line holds no pending beat. The first COL beat appears the cycle after the last o_wen.
- COL: behaves like ROW, but drives o_col_valid and o_col_idx. i_stall holds it the same way.
- DONE: o_done=1 for exactly one cycle, with o_busy still 1.
- Ignored inputs:
  - i_start outside IDLE is ignored and not queued.
  - i_transize changes after the latch have no effect.
- Reset, including mid-TU, returns to IDLE on the next edge:
  - Counters and delay line are cleared.
  - All outputs return to 0.
  - The TU is abandoned with no o_done.

## Timing

- All outputs are registered.
- Reset values:
  - o_busy, o_row_valid, o_wen, o_col_valid and o_done reset to 0.
  - o_row_idx and o_col_idx reset to 0.
- Unstalled TU, with start accepted at cycle 0:
  - Row beats occur on cycles 1..N.
  - o_wen is high on cycles 1+ROW_LAT..N+ROW_LAT.
  - Column beats occur on cycles N+ROW_LAT+1..2N+ROW_LAT.
  - o_done is high on cycle 2N+ROW_LAT+1.
  - o_busy is high on cycles 1..2N+ROW_LAT+1.
- Total latency from start to o_done is 2N+ROW_LAT+1 cycles.
- Back-to-back TUs: the earliest next start is sampled in the first IDLE cycle (cycle 2N+ROW_LAT+2).
- o_row_valid and o_col_valid are never high in the same cycle.
- o_wen and o_col_valid are never high in the same cycle.
- i_stall held throughout FLUSH or DONE has no effect.

## Test plan

- 4x4 TU with ROW_LAT=2, start at cycle 0:
  - row beat at c1 (idx0), o_wen at c3, col beat at c4 (idx0), o_done at c5, o_busy low at c6.
- 32x32 TU, unstalled:
  - 32 row beats with idx 0..31, 32 o_wen pulses at c3..c34, col idx 0..31 at c35..c66, o_done at c67.
- 8x8 TU with i_stall=1 on cycle 2 only:
  - row idx0 at c1, no beat at c2, idx1 at c3.
  - o_wen at c3 and c5 with a gap at c4.
  - col beats at c6..c7, o_done at c8.
- Two 16x16 TUs, the second start held high continuously:
  - the second TU is accepted only in the first IDLE cycle after o_done.
  - i_transize changed mid-TU does not alter N (8 beats).
- rst pulsed while in COL of a 32x32 TU:
  - all outputs are 0 on the next cycle and no o_done occurs.
  - a fresh 4x4 start then completes with the nominal timing.
